hub_slot_arb: RTL and testbench

//  Round-robin time-slot arbiter directly upstream of hub_mem. It multiplexes the
//  NUM_COGS cog hub-access requests onto hub_mem's single w/wb/a/d port, one slot per
//  ena_bus cycle. It captures hub_mem's q and returns it, with a one-hot ack, to the
//  cog that owned the slot. Writes to ROM space are blocked here.

---
 rtl/hub_pkg.sv | 23 ++
 rtl/hub_slot_mux.sv | 33 +++
 rtl/hub_slot_arb.sv | 105 ++++++++++
 tb/tb_hub_slot_arb.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/hub_pkg.sv
// Shared constants and field helpers for the hub slot arbiter and its selector.
package hub_pkg;

    localparam int NUM_COGS   = 8;
    localparam int HUB_ADDR_W = 14;
    localparam int SLOT_W     = $clog2(NUM_COGS);

    // Long addresses with this bit set live in ROM and must never be written.
    localparam int ROM_BIT    = HUB_ADDR_W - 1;

    // Pull cog idx's 32-bit word out of a flattened per-cog data bus.
    function automatic logic [31:0] cog_word(input logic [32*NUM_COGS-1:0] bus,
                                             input logic [SLOT_W-1:0]      idx);
        return bus[32*idx +: 32];
    endfunction

    // Pull cog idx's long address out of a flattened per-cog address bus.
    function automatic logic [HUB_ADDR_W-1:0] cog_addr(input logic [HUB_ADDR_W*NUM_COGS-1:0] bus,
                                                       input logic [SLOT_W-1:0]              idx);
        return bus[HUB_ADDR_W*idx +: HUB_ADDR_W];
    endfunction

endpackage

// File: rtl/hub_slot_mux.sv
// Combinational selector that presents the slot owner's request fields to the hub port.
module hub_slot_mux
    import hub_pkg::*;
(
    input  logic [SLOT_W-1:0]              slot_i,
    input  logic [NUM_COGS-1:0]            req_i,
    input  logic [NUM_COGS-1:0]            ena_i,
    input  logic [NUM_COGS-1:0]            w_i,
    input  logic [4*NUM_COGS-1:0]          wb_i,
    input  logic [HUB_ADDR_W*NUM_COGS-1:0] a_i,
    input  logic [32*NUM_COGS-1:0]         d_i,
    output logic                           req_o,
    output logic                           w_o,
    output logic [3:0]                     wb_o,
    output logic [HUB_ADDR_W-1:0]          a_o,
    output logic [31:0]                    d_o
);

    // Route the slot owner's fields; a stopped cog's request reads as idle.
    always_comb begin
        req_o = 1'b0;
        w_o   = 1'b0;
        wb_o  = '0;
        a_o   = '0;
        d_o   = '0;
        req_o = req_i[slot_i] & ena_i[slot_i];
        w_o   = w_i[slot_i];
        wb_o  = wb_i[4*slot_i +: 4];
        a_o   = cog_addr(a_i, slot_i);
        d_o   = cog_word(d_i, slot_i);
    end

endmodule

// File: rtl/hub_slot_arb.sv
// Round-robin hub slot arbiter: one cog per ena_bus cycle drives hub_mem, and the
// returned q is handed back with a one-hot ack on the following bus slot.
module hub_slot_arb
    import hub_pkg::*;
(
    input  logic                           clk_cog,
    input  logic                           res,
    input  logic                           ena_bus,
    input  logic [NUM_COGS-1:0]            cog_ena,
    input  logic [NUM_COGS-1:0]            req,
    input  logic [NUM_COGS-1:0]            req_w,
    input  logic [4*NUM_COGS-1:0]          req_wb,
    input  logic [HUB_ADDR_W*NUM_COGS-1:0] req_a,
    input  logic [32*NUM_COGS-1:0]         req_d,
    output logic                           mem_w,
    output logic [3:0]                     mem_wb,
    output logic [HUB_ADDR_W-1:0]          mem_a,
    output logic [31:0]                    mem_d,
    input  logic [31:0]                    mem_q,
    output logic [NUM_COGS-1:0]            ack,
    output logic [31:0]                    rdata,
    output logic [SLOT_W-1:0]              slot
);

    logic [SLOT_W-1:0]   slot_q,    slot_d;
    logic                pend_q,    pend_d;
    logic [SLOT_W-1:0]   pendCog_q, pendCog_d;
    logic [NUM_COGS-1:0] ack_q,     ack_d;
    logic [31:0]         rdata_q,   rdata_d;

    logic selReq;
    logic selW;
    logic grant;

    hub_slot_mux uMux (
        .slot_i (slot_q),
        .req_i  (req),
        .ena_i  (cog_ena),
        .w_i    (req_w),
        .wb_i   (req_wb),
        .a_i    (req_a),
        .d_i    (req_d),
        .req_o  (selReq),
        .w_o    (selW),
        .wb_o   (mem_wb),
        .a_o    (mem_a),
        .d_o    (mem_d)
    );

    // Issue side: ROM-space writes degrade to reads, and reset blocks any write.
    always_comb begin
        grant = 1'b0;
        mem_w = 1'b0;
        grant = ena_bus & selReq;
        mem_w = selReq & selW & ~mem_a[ROM_BIT] & ~res;
    end

    // Next-state: advance the slot, track the in-flight access, complete the previous one.
    always_comb begin
        slot_d    = slot_q;
        pend_d    = pend_q;
        pendCog_d = pendCog_q;
        ack_d     = '0;
        rdata_d   = rdata_q;
        if (ena_bus) begin
            if (slot_q == SLOT_W'(NUM_COGS - 1)) begin
                slot_d = '0;
            end else begin
                slot_d = slot_q + 1'b1;
            end
            pend_d = grant;
            if (grant) begin
                pendCog_d = slot_q;
            end
            if (pend_q) begin
                rdata_d = mem_q;
                if (cog_ena[pendCog_q]) begin
                    ack_d[pendCog_q] = 1'b1;
                end
            end
        end
    end

    // State registers with synchronous reset that drops any access in flight.
    always_ff @(posedge clk_cog) begin
        if (res) begin
            slot_q    <= '0;
            pend_q    <= 1'b0;
            pendCog_q <= '0;
            ack_q     <= '0;
            rdata_q   <= '0;
        end else begin
            slot_q    <= slot_d;
            pend_q    <= pend_d;
            pendCog_q <= pendCog_d;
            ack_q     <= ack_d;
            rdata_q   <= rdata_d;
        end
    end

    assign ack   = ack_q;
    assign rdata = rdata_q;
    assign slot  = slot_q;

endmodule

// File: tb/tb_hub_slot_arb.sv
// Directed bench for hub_slot_arb with a behavioural hub_mem behind it.
module tb_hub_slot_arb;

    logic          clk_cog = 1'b0;
    logic          res     = 1'b1;
    logic          ena_bus = 1'b0;
    logic [7:0]    cog_ena = '0;
    logic [7:0]    req     = '0;
    logic [7:0]    req_w   = '0;
    logic [31:0]   req_wb  = '0;
    logic [111:0]  req_a   = '0;
    logic [255:0]  req_d   = '0;
    logic          mem_w;
    logic [3:0]    mem_wb;
    logic [13:0]   mem_a;
    logic [31:0]   mem_d;
    logic [31:0]   mem_q   = '0;
    logic [7:0]    ack;
    logic [31:0]   rdata;
    logic [2:0]    slot;

    int            checks  = 0;
    int            errors  = 0;
    logic [2:0]    expSlot = '0;
    logic [31:0]   ackRdata;
    logic [31:0]   ram [int];

    hub_slot_arb dut (
        .clk_cog (clk_cog),
        .res     (res),
        .ena_bus (ena_bus),
        .cog_ena (cog_ena),
        .req     (req),
        .req_w   (req_w),
        .req_wb  (req_wb),
        .req_a   (req_a),
        .req_d   (req_d),
        .mem_w   (mem_w),
        .mem_wb  (mem_wb),
        .mem_a   (mem_a),
        .mem_d   (mem_d),
        .mem_q   (mem_q),
        .ack     (ack),
        .rdata   (rdata),
        .slot    (slot)
    );

    // Free-running system clock.
    always #5 clk_cog = ~clk_cog;

    // Unwritten locations read back a recognisable address-derived pattern.
    function automatic logic [31:0] memRead(input logic [13:0] a);
        if (ram.exists(int'(a))) begin
            return ram[int'(a)];
        end
        return 32'h5A00_0000 | {18'd0, a};
    endfunction

    // Behavioural hub_mem: reads return old data, writes honour byte enables.
    always @(posedge clk_cog) begin
        if (ena_bus) begin
            logic [31:0] merged;
            mem_q <= memRead(mem_a);
            if (mem_w) begin
                merged = memRead(mem_a);
                for (int b = 0; b < 4; b++) begin
                    if (mem_wb[b]) begin
                        merged[8*b +: 8] = mem_d[8*b +: 8];
                    end
                end
                ram[int'(mem_a)] = merged;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic cycle(input logic ena);
        ena_bus = ena;
        @(posedge clk_cog);
        #1;
    endtask

    // One bus slot: an ena_bus edge followed by an idle edge. The ack seen after the
    // enabled edge is compared and must be gone after the idle one.
    task automatic applyStimulus(input logic [7:0] expAck, input string tag);
        expSlot = res ? 3'd0 : expSlot + 3'd1;
        cycle(1'b1);
        ackRdata = rdata;
        checkOutput({tag, "-ack"}, 32'(ack), 32'(expAck));
        checkOutput({tag, "-slot"}, 32'(slot), 32'(expSlot));
        cycle(1'b0);
        checkOutput({tag, "-ackdrop"}, 32'(ack), 32'd0);
    endtask

    task automatic advanceTo(input int cog);
        for (int n = 0; n < 8 && int'(expSlot) != cog; n++) begin
            applyStimulus(8'h00, "idle");
        end
    endtask

    task automatic setReq(input int c, input logic w, input logic [13:0] a,
                          input logic [31:0] d, input logic [3:0] wb);
        req[c]            = 1'b1;
        req_w[c]          = w;
        req_a[c*14 +: 14] = a;
        req_d[c*32 +: 32] = d;
        req_wb[c*4 +: 4]  = wb;
    endtask

    // Directed sequence covering reset, slot rotation, reads, writes, ROM protection,
    // reset mid-access and a cog stopping mid-access.
    initial begin
        res = 1'b1;
        cycle(1'b0);
        cycle(1'b1);
        cycle(1'b0);
        checkOutput("rst-slot", 32'(slot), 32'd0);
        checkOutput("rst-ack", 32'(ack), 32'd0);
        checkOutput("rst-rdata", rdata, 32'd0);
        cog_ena = 8'hFF;
        setReq(0, 1'b1, 14'h0010, 32'hCAFE_F00D, 4'hF);
        #1;
        checkOutput("rst-memw", 32'(mem_w), 32'd0);
        req = '0;
        req_w = '0;

        // Test 1: free-running slots with no requests.
        res = 1'b0;
        expSlot = 3'd0;
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(8'h00, "t1");
            checkOutput("t1-memw", 32'(mem_w), 32'd0);
        end

        // Test 2: cog 3 writes then reads back.
        advanceTo(3);
        setReq(3, 1'b1, 14'h0010, 32'hDEAD_BEEF, 4'hF);
        #1;
        checkOutput("t2-memw", 32'(mem_w), 32'd1);
        checkOutput("t2-mema", 32'(mem_a), 32'h0010);
        checkOutput("t2-memd", mem_d, 32'hDEAD_BEEF);
        checkOutput("t2-memwb", 32'(mem_wb), 32'hF);
        applyStimulus(8'h00, "t2-wgrant");
        applyStimulus(8'h08, "t2-wdone");
        req[3] = 1'b0;
        advanceTo(3);
        setReq(3, 1'b0, 14'h0010, 32'h0, 4'h0);
        #1;
        checkOutput("t2-rmemw", 32'(mem_w), 32'd0);
        applyStimulus(8'h00, "t2-rgrant");
        applyStimulus(8'h08, "t2-rdone");
        checkOutput("t2-rdata", ackRdata, 32'hDEAD_BEEF);
        req[3] = 1'b0;

        // Test 3: every cog reads at once; acks come back in slot order.
        advanceTo(0);
        for (int i = 0; i < 8; i++) begin
            setReq(i, 1'b0, 14'h0100 + 14'(i), 32'h0, 4'h0);
        end
        applyStimulus(8'h00, "t3-g0");
        for (int j = 1; j <= 8; j++) begin
            applyStimulus(8'(1 << (j - 1)), "t3");
            checkOutput("t3-rdata", ackRdata, 32'h5A00_0100 + 32'(j - 1));
            req[j-1] = 1'b0;
        end

        // Test 4: cog 5 write into ROM is blocked but still acked.
        advanceTo(5);
        setReq(5, 1'b1, 14'h2000, 32'h1234_5678, 4'hF);
        #1;
        checkOutput("t4-memw", 32'(mem_w), 32'd0);
        checkOutput("t4-mema", 32'(mem_a), 32'h2000);
        applyStimulus(8'h00, "t4-wgrant");
        applyStimulus(8'h20, "t4-wdone");
        req[5] = 1'b0;
        advanceTo(5);
        setReq(5, 1'b0, 14'h2000, 32'h0, 4'h0);
        applyStimulus(8'h00, "t4-rgrant");
        applyStimulus(8'h20, "t4-rdone");
        checkOutput("t4-rdata", ackRdata, 32'h5A00_2000);
        req[5] = 1'b0;

        // Test 5: reset lands between grant and completion, then covers a write edge.
        advanceTo(2);
        setReq(2, 1'b0, 14'h0020, 32'h0, 4'h0);
        applyStimulus(8'h00, "t5-grant");
        res = 1'b1;
        applyStimulus(8'h00, "t5-rst");
        req[2] = 1'b0;
        setReq(0, 1'b1, 14'h0020, 32'h1111_1111, 4'hF);
        #1;
        checkOutput("t5-rstmemw", 32'(mem_w), 32'd0);
        applyStimulus(8'h00, "t5-rstw");
        req = '0;
        req_w = '0;
        res = 1'b0;
        applyStimulus(8'h00, "t5-rel");
        advanceTo(2);
        setReq(2, 1'b0, 14'h0020, 32'h0, 4'h0);
        applyStimulus(8'h00, "t5-rgrant");
        applyStimulus(8'h04, "t5-rdone");
        checkOutput("t5-rdata", ackRdata, 32'h5A00_0020);
        req[2] = 1'b0;

        // Test 6: cog 6 stops mid-access; cog 7 behind it completes normally.
        advanceTo(6);
        setReq(6, 1'b0, 14'h0060, 32'h0, 4'h0);
        setReq(7, 1'b0, 14'h0070, 32'h0, 4'h0);
        applyStimulus(8'h00, "t6-grant6");
        cog_ena[6] = 1'b0;
        applyStimulus(8'h00, "t6-supp");
        checkOutput("t6-rdata6", ackRdata, 32'h5A00_0060);
        applyStimulus(8'h80, "t6-done7");
        checkOutput("t6-rdata7", ackRdata, 32'h5A00_0070);
        req = '0;
        cog_ena = 8'hFF;
        applyStimulus(8'h00, "t6-idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
